// File: rtl/spi_xfer_ctrl.sv
// Byte-level SPI transfer controller: TX FIFO feeds a single outstanding SPI
// transfer, whose received byte lands in an RX FIFO read by the host.
module spi_xfer_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   tx_full,
  output logic [$clog2(DEPTH):0] tx_count,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   rx_empty,
  output logic [$clog2(DEPTH):0] rx_count,
  input  logic                   clr_err,
  output logic                   tx_ovf,
  output logic                   rx_udf,
  output logic                   spi_start,
  output logic [7:0]             spi_tx_data,
  input  logic [7:0]             spi_rx_data,
  input  logic                   spi_done,
  input  logic                   spi_busy,
  output logic [1:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e        state_q;
  logic          spi_start_q;
  logic [7:0]    spi_tx_data_q;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
  logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic          tx_ovf_q, rx_udf_q;

  logic tx_push, tx_pop, rx_push, rx_pop, issue;

  // An issue requires a free RX slot, so the byte returned by this transfer
  // always has somewhere to go and the RX FIFO cannot overflow.
  assign issue   = (state_q == IDLE) && (tx_count_q != '0) &&
                   (rx_count_q < DEPTH_C) && !spi_busy;
  assign tx_pop  = issue;
  assign tx_push = wr_en && !tx_full;
  assign rx_push = (state_q == WAIT) && spi_done;
  assign rx_pop  = rd_en && !rx_empty;

  assign tx_full     = (tx_count_q == DEPTH_C);
  assign rx_empty    = (rx_count_q == '0);
  assign tx_count    = tx_count_q;
  assign rx_count    = rx_count_q;
  assign rd_data     = rx_mem[rx_rd_ptr_q];
  assign tx_ovf      = tx_ovf_q;
  assign rx_udf      = rx_udf_q;
  assign spi_start   = spi_start_q;
  assign spi_tx_data = spi_tx_data_q;
  assign dbg_state   = state_q;

  always_comb begin
    tx_count_d = tx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CNT_ONE;
      2'b01:   tx_count_d = tx_count_q - CNT_ONE;
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_comb begin
    rx_count_d = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CNT_ONE;
      2'b01:   rx_count_d = rx_count_q - CNT_ONE;
      default: rx_count_d = rx_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= wr_data;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= spi_rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_count_q  <= '0;
      tx_ovf_q    <= 1'b0;
      rx_udf_q    <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PTR_ONE;
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PTR_ONE;
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PTR_ONE;
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PTR_ONE;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      // Clear wins over a same-cycle error event.
      if (clr_err) begin
        tx_ovf_q <= 1'b0;
        rx_udf_q <= 1'b0;
      end else begin
        if (wr_en && tx_full)  tx_ovf_q <= 1'b1;
        if (rd_en && rx_empty) rx_udf_q <= 1'b1;
      end
    end
  end

  // spi_done is only honoured in WAIT, so stray pulses elsewhere are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      spi_start_q   <= 1'b0;
      spi_tx_data_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          spi_start_q <= 1'b0;
          if (issue) begin
            state_q       <= START;
            spi_start_q   <= 1'b1;
            spi_tx_data_q <= tx_mem[tx_rd_ptr_q];
          end
        end
        START: begin
          state_q     <= WAIT;
          spi_start_q <= 1'b0;
        end
        WAIT: begin
          spi_start_q <= 1'b0;
          if (spi_done) state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          spi_start_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: queue-based reference model checked every cycle,
// directed scenarios followed by a randomized run.
module tb_spi_xfer_ctrl;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en, clr_err, spi_done, spi_busy;
  logic [7:0]    wr_data, spi_rx_data;
  logic          tx_full, rx_empty, tx_ovf, rx_udf, spi_start;
  logic [CW-1:0] tx_count, rx_count;
  logic [7:0]    rd_data, spi_tx_data;
  logic [1:0]    dbg_state;

  spi_xfer_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_count(tx_count),
    .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .clr_err(clr_err), .tx_ovf(tx_ovf), .rx_udf(rx_udf),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_rx_data(spi_rx_data),
    .spi_done(spi_done), .spi_busy(spi_busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int         checks = 0;
  int         failures = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int         m_phase;      // 0 nothing outstanding, 1 start-pulse cycle, 2 awaiting done
  logic [7:0] m_tx_byte;
  logic       m_ovf, m_udf;

  // slave / stimulus state
  int         slave_wait = 0;
  bit         slave_stall = 0;
  bit         loopback = 1;
  bit         force_done = 0;
  bit         rd_on_done = 0;
  bit         coinc_seen = 0;
  int         starts = 0;
  bit         ff_sent = 0;
  logic [7:0] last_start_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    exp_q.delete();
    m_phase   = 0;
    m_tx_byte = 8'h00;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
  endtask

  // Applies the transfer rules to the inputs present at this rising edge.
  task automatic model_edge();
    bit full, empty, issue, done_acc;
    full     = (tx_q.size() == DEPTH);
    empty    = (exp_q.size() == 0);
    issue    = (m_phase == 0) && (tx_q.size() > 0) && (exp_q.size() < DEPTH) && !spi_busy;
    done_acc = (m_phase == 2) && spi_done;
    if (rd_en && !empty) void'(exp_q.pop_front());
    if (done_acc) exp_q.push_back(spi_rx_data);
    if (issue) m_tx_byte = tx_q.pop_front();
    if (wr_en && !full) tx_q.push_back(wr_data);
    m_ovf = clr_err ? 1'b0 : (m_ovf | (wr_en && full));
    m_udf = clr_err ? 1'b0 : (m_udf | (rd_en && empty));
    if (m_phase == 0 && issue) m_phase = 1;
    else if (m_phase == 1) m_phase = 2;
    else if (done_acc) m_phase = 0;
  endtask

  task automatic compare_all();
    check("spi_start", spi_start, m_phase == 1);
    check("spi_tx_data", spi_tx_data, m_tx_byte);
    check("tx_count", tx_count, tx_q.size());
    check("tx_full", tx_full, tx_q.size() == DEPTH);
    check("rx_count", rx_count, exp_q.size());
    check("rx_empty", rx_empty, exp_q.size() == 0);
    check("tx_ovf", tx_ovf, m_ovf);
    check("rx_udf", rx_udf, m_udf);
    if (exp_q.size() > 0) check("rd_data", rd_data, exp_q[0]);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
    if (spi_start === 1'b1) begin
      starts++;
      last_start_byte = spi_tx_data;
      if (spi_tx_data == 8'hFF) ff_sent = 1;
      slave_wait = 2 + int'($urandom_range(0, 3));
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic w, input logic [7:0] wd, input logic r);
    bit coinc;
    int coinc_before;
    coinc        = 0;
    coinc_before = 0;
    wr_en   = w;
    wr_data = wd;
    rd_en   = r;
    spi_done = 1'b0;
    if (slave_wait > 0 && !slave_stall) begin
      slave_wait--;
      if (slave_wait == 0) begin
        spi_done    = 1'b1;
        spi_rx_data = loopback ? spi_tx_data : 8'($urandom);
      end
    end else if (force_done && slave_wait == 0) begin
      spi_done    = 1'b1;
      spi_rx_data = 8'($urandom);
    end
    force_done = 0;
    if (rd_on_done && spi_done) begin
      rd_en        = 1'b1;
      coinc        = 1;
      coinc_before = exp_q.size();
    end
    step();
    if (coinc) begin
      coinc_seen = 1;
      check("coinc_rx_count", rx_count, coinc_before);
    end
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    spi_done = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic apply_reset();
    wr_en = 0; rd_en = 0; clr_err = 0; spi_done = 0; spi_busy = 0;
    rst_n = 1'b0;
    #2;
    model_reset();
    slave_wait = 0;
    check("rst_tx_count", tx_count, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_tx_data", spi_tx_data, 8'h00);
    check("rst_tx_ovf", tx_ovf, 0);
    check("rst_rx_udf", rx_udf, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    wr_en = 0; rd_en = 0; clr_err = 0; spi_done = 0; spi_busy = 0;
    wr_data = 8'h00; spi_rx_data = 8'h00;
    model_reset();
    #3;
    apply_reset();

    // single byte, loopback, start latency
    starts = 0;
    cycle(1'b1, 8'hA5, 1'b0);
    check("lat_no_start_yet", spi_start, 0);
    cycle(1'b0, 8'h00, 1'b0);
    check("lat_start_2nd_cycle", spi_start, 1);
    idle_cycles(9);
    check("a5_starts", starts, 1);
    check("a5_tx_data", spi_tx_data, 8'hA5);
    check("a5_rd_data", rd_data, 8'hA5);
    check("a5_rx_count", rx_count, 1);
    cycle(1'b0, 8'h00, 1'b1);
    check("a5_drained", rx_empty, 1);

    // eight bytes back to back
    starts = 0;
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0);
    idle_cycles(80);
    check("b2b_starts", starts, 8);
    check("b2b_rx_count", rx_count, 8);
    check("b2b_tx_ovf", tx_ovf, 0);
    check("b2b_rx_udf", rx_udf, 0);

    // RX full blocks issue until one read
    starts = 0;
    cycle(1'b1, 8'h55, 1'b0);
    idle_cycles(10);
    check("rxfull_no_start", starts, 0);
    check("rxfull_tx_pending", tx_count, 1);
    check("rxfull_head", rd_data, 8'h01);
    cycle(1'b0, 8'h00, 1'b1);
    idle_cycles(15);
    check("rxfull_one_start", starts, 1);
    check("rxfull_byte", last_start_byte, 8'h55);
    check("rxfull_rx_count", rx_count, 8);
    for (int i = 0; i < 8; i++) begin
      check("rxfull_drain", rd_data, (i < 7) ? 8'(i + 2) : 8'h55);
      cycle(1'b0, 8'h00, 1'b1);
    end
    check("rxfull_empty", rx_empty, 1);

    // TX overflow while the master reports busy
    spi_busy = 1'b1;
    ff_sent  = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    check("ovf_flag", tx_ovf, 1);
    check("ovf_count", tx_count, 8);
    check("ovf_full", tx_full, 1);
    clr_err = 1'b1;
    cycle(1'b1, 8'hFF, 1'b0);
    clr_err = 1'b0;
    check("ovf_clr_priority", tx_ovf, 0);
    spi_busy = 1'b0;
    idle_cycles(80);
    check("ovf_ff_never_sent", ff_sent, 0);
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain", rd_data, 8'h10 + 8'(i));
      cycle(1'b0, 8'h00, 1'b1);
    end

    // underflow, then read coincident with a push
    cycle(1'b0, 8'h00, 1'b1);
    check("udf_flag", rx_udf, 1);
    check("udf_rx_count", rx_count, 0);
    clr_err = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    clr_err = 1'b0;
    check("udf_cleared", rx_udf, 0);
    cycle(1'b1, 8'h66, 1'b0);
    idle_cycles(12);
    rd_on_done = 1;
    coinc_seen = 0;
    cycle(1'b1, 8'h77, 1'b0);
    for (int k = 0; k < 20 && !coinc_seen; k++) cycle(1'b0, 8'h00, 1'b0);
    rd_on_done = 0;
    check("coinc_seen", coinc_seen, 1);
    check("coinc_head", rd_data, 8'h77);

    // reset during a stalled transfer, then a stale done
    slave_stall = 1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h31 + 8'(i), 1'b0);
    idle_cycles(5);
    check("stall_queued", tx_count, 3);
    apply_reset();
    slave_stall = 0;
    starts = 0;
    force_done = 1;
    cycle(1'b0, 8'h00, 1'b0);
    check("stale_done_rx_count", rx_count, 0);
    check("stale_done_rx_empty", rx_empty, 1);
    idle_cycles(5);
    check("post_rst_no_start", starts, 0);

    // randomized traffic
    loopback = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) apply_reset();
      spi_busy   = ($urandom_range(0, 9) == 0);
      clr_err    = ($urandom_range(0, 19) == 0);
      force_done = ($urandom_range(0, 29) == 0);
      if (i < 750)
        cycle($urandom_range(0, 1) == 0, 8'($urandom), $urandom_range(0, 3) == 0);
      else
        cycle($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 1) == 0);
    end
    spi_busy = 0;
    clr_err  = 0;
    idle_cycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
